// File: rtl/alu_div_pkg.sv
// Shared types and constants for the sequential RV32M divider.
// Contents: div_op_e (op encoding), div_state_e (FSM states),
// DIV_BY_ZERO_Q and INT_MIN special-result constants.
package alu_div_pkg;

  typedef enum logic [1:0] {
    OpDiv  = 2'b00,
    OpDivu = 2'b01,
    OpRem  = 2'b10,
    OpRemu = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StCalc = 2'b01,
    StFin  = 2'b10
  } div_state_e;

  localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN       = 32'h8000_0000;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quo} left by one, trial-subtract the
// divisor from the shifted remainder at XLEN+1 bits, and keep or restore.
// Ports:
//   rem, quo      current partial remainder / quotient
//   divisor_mag   divisor magnitude
//   rem_next      remainder after this iteration
//   quo_next      quotient after this iteration (new bit shifted in at LSB)
module div_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor_mag,
  output logic [XLEN-1:0] rem_next,
  output logic [XLEN-1:0] quo_next
);

  logic [XLEN:0] rem_sh;
  logic [XLEN:0] trial;
  logic          borrow;

  assign rem_sh = {rem, quo[XLEN-1]};

  // Subtract via the adder in subtract mode: a + ~b + 1, widened by one bit so the
  // MSB of the result is the borrow.
  assign trial  = rem_sh + {1'b1, ~divisor_mag} + {{XLEN{1'b0}}, 1'b1};
  assign borrow = trial[XLEN];

  // On borrow the shifted remainder is below the divisor, so its MSB is zero and
  // dropping it is lossless.
  assign rem_next = borrow ? rem_sh[XLEN-1:0] : trial[XLEN-1:0];
  assign quo_next = {quo[XLEN-2:0], ~borrow};

endmodule

// File: rtl/alu_div_seq.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   start           request pulse, accepted only when idle
//   op              00=DIV 01=DIVU 10=REM 11=REMU, captured with start
//   dividend        rs1, captured with start
//   divisor         rs2, captured with start
//   busy            high from the cycle after an accepted start through done
//   done            one-cycle pulse, result valid in this cycle
//   result          quotient or remainder, held until overwritten by the next op
module alu_div_seq
  import alu_div_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  div_state_e       state_q;
  div_op_e          op_q;
  logic [XLEN-1:0]  rem_q;
  logic [XLEN-1:0]  quo_q;
  logic [XLEN-1:0]  dvs_q;
  logic [CNT_W-1:0] cnt_q;
  logic             q_neg_q;
  logic             r_neg_q;
  logic             busy_q;
  logic             done_q;
  logic [XLEN-1:0]  result_q;

  // Operand conditioning for the start cycle.
  div_op_e         op_in;
  logic            is_signed;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            div_zero;
  logic            ovf;

  always_comb begin
    op_in     = div_op_e'(op);
    is_signed = (op_in == OpDiv) || (op_in == OpRem);
    a_neg     = is_signed & dividend[XLEN-1];
    b_neg     = is_signed & divisor[XLEN-1];
    // |INT_MIN| wraps back to INT_MIN, which is the correct unsigned magnitude.
    a_mag     = a_neg ? (~dividend + XLEN'(1)) : dividend;
    b_mag     = b_neg ? (~divisor + XLEN'(1)) : divisor;
    div_zero  = (divisor == '0);
    ovf       = is_signed && (dividend == INT_MIN) && (divisor == '1);
  end

  logic [XLEN-1:0] rem_next;
  logic [XLEN-1:0] quo_next;

  div_step #(
    .XLEN (XLEN)
  ) u_div_step (
    .rem         (rem_q),
    .quo         (quo_q),
    .divisor_mag (dvs_q),
    .rem_next    (rem_next),
    .quo_next    (quo_next)
  );

  // Sign correction and op select for the finishing cycle.
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;
  logic [XLEN-1:0] fin_res;

  always_comb begin
    quo_fix = q_neg_q ? (~quo_q + XLEN'(1)) : quo_q;
    rem_fix = r_neg_q ? (~rem_q + XLEN'(1)) : rem_q;
    fin_res = quo_fix;
    unique case (op_q)
      OpDiv, OpDivu: fin_res = quo_fix;
      OpRem, OpRemu: fin_res = rem_fix;
      default:       fin_res = quo_fix;
    endcase
  end

  // busy and done are registered and trail the state by one cycle, so the done
  // cycle still reads as busy and a start there is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      op_q     <= OpDiv;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (busy_q) begin
            busy_q <= 1'b0;
          end else if (start) begin
            busy_q  <= 1'b1;
            op_q    <= op_in;
            cnt_q   <= '0;
            dvs_q   <= b_mag;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            if (div_zero) begin
              // Special results ride through StFin with no sign correction.
              quo_q   <= DIV_BY_ZERO_Q;
              rem_q   <= dividend;
              state_q <= StFin;
            end else if (ovf) begin
              quo_q   <= INT_MIN;
              rem_q   <= '0;
              state_q <= StFin;
            end else begin
              quo_q   <= a_mag;
              rem_q   <= '0;
              q_neg_q <= a_neg ^ b_neg;
              r_neg_q <= a_neg;
              state_q <= StCalc;
            end
          end
        end
        StCalc: begin
          rem_q <= rem_next;
          quo_q <= quo_next;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(XLEN - 1)) begin
            state_q <= StFin;
          end
        end
        StFin: begin
          result_q <= fin_res;
          done_q   <= 1'b1;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_alu_div_seq.sv
module tb_alu_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] result;

  alu_div_seq #(
    .XLEN  (32),
    .CNT_W (6)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_entry_t;

  sb_entry_t sb[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Independent reference model of the RV32M division semantics.
  function automatic logic [31:0] model_res(input logic [1:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    logic ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (o)
      2'b00:   model_res = (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 :
                           32'($signed(a) / $signed(b));
      2'b01:   model_res = (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'b10:   model_res = (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
      default: model_res = (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_lat(input logic [1:0] o, input logic [31:0] a,
                                   input logic [31:0] b);
    bit sgn;
    sgn = (o == 2'b00) || (o == 2'b10);
    if (b == 0 || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) model_lat = 2;
    else model_lat = 34;
  endfunction

  // Monitor: every done pops one expected result.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        sb_entry_t e;
        e = sb.pop_front();
        check(e.tag, result, e.exp);
      end
    end
  end

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat,
                        input bit poke);
    int cyc;
    bit busy_ok;
    @(negedge clk);
    start = 1'b1; op = o; dividend = a; divisor = b;
    sb.push_back('{tag, exp});
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    busy_ok = 1'b1;
    while (!done && cyc < 100) begin
      if (!busy) busy_ok = 1'b0;
      if (poke && (cyc == 5 || cyc == 20)) begin
        start = 1'b1; op = 2'b00; dividend = 32'd6; divisor = 32'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    if (!busy) busy_ok = 1'b0;
    check({tag, "_latency"}, 32'(cyc), 32'(lat));
    check({tag, "_busy"}, 32'(busy_ok), 32'd1);
    if (poke) begin
      start = 1'b1; op = 2'b10; dividend = 32'd6; divisor = 32'd4;
    end
    @(negedge clk);
    start = 1'b0;
    check({tag, "_idle_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; dividend = '0; divisor = '0;
    #2;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", result, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14, 34, 1'b0);
    run_op("remu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 34, 1'b0);
    run_op("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 1'b0);
    run_op("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 1'b0);
    run_op("rem_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 34, 1'b0);
    run_op("div_by0", 2'b00, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 2, 1'b0);
    run_op("divu_by0", 2'b01, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 2, 1'b0);
    run_op("rem_by0", 2'b10, 32'h1234_5678, 32'd0, 32'h1234_5678, 2, 1'b0);
    run_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2, 1'b0);
    run_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 2, 1'b0);
    run_op("divu_ovf_ops", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 34, 1'b0);
    run_op("div_zero_dvd", 2'b00, 32'd0, 32'd5, 32'd0, 34, 1'b0);
    run_op("divu_ignore", 2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34, 1'b1);
    run_op("accept_after", 2'b11, 32'd17, 32'd5, 32'd2, 34, 1'b0);

    // Reset in the middle of an operation: no done may ever follow.
    @(negedge clk);
    start = 1'b1; op = 2'b01; dividend = 32'd1000; divisor = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("rst_quiet_busy", 32'(busy), 32'd0);
    run_op("divu_9_3", 2'b01, 32'd9, 32'd3, 32'd3, 34, 1'b0);

    for (int i = 0; i < 8; i++) begin
      logic [1:0]  ro;
      logic [31:0] ra;
      logic [31:0] rb;
      ro = 2'($urandom_range(0, 3));
      ra = $urandom();
      rb = $urandom() >> $urandom_range(0, 30);
      if (rb == 0) rb = 32'd1;
      run_op("rand", ro, ra, rb, model_res(ro, ra, rb), model_lat(ro, ra, rb), 1'b0);
    end

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
